// File: rtl/otter_fetch_pkg.sv
// Shared types and constants for the OTTER instruction-fetch stage.
package otter_fetch_pkg;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'd0,
        PC_JALR   = 2'd1,
        PC_BRANCH = 2'd2,
        PC_JAL    = 2'd3
    } pc_sel_t;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DROP
    } fetch_state_t;

    localparam logic [31:0] OTTER_NOP = 32'h0000_0013;

endpackage

// File: rtl/otter_fetch_skid.sv
// One-entry holding buffer for an instruction that returns while the pipe is stalled.
module otter_fetch_skid
    import otter_fetch_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        push_i,
    input  logic        pop_i,
    input  logic        clear_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    output logic        full_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o
);

    logic        full_q;
    logic [31:0] instr_q;
    logic [31:0] pc_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            full_q  <= 1'b0;
            instr_q <= OTTER_NOP;
            pc_q    <= '0;
        end else if (clear_i) begin
            full_q  <= 1'b0;
        end else if (push_i) begin
            full_q  <= 1'b1;
            instr_q <= instr_i;
            pc_q    <= pc_i;
        end else if (pop_i) begin
            full_q  <= 1'b0;
        end
    end

    assign full_o  = full_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/otter_fetch_stage.sv
// OTTER IF stage: PC, next-PC mux, single-outstanding imem FSM and IF/DE register.
// Define OTTER_FETCH_PERF_EN to add saturating redirect/wait/stall counters.
module otter_fetch_stage
    import otter_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
`ifdef OTTER_FETCH_PERF_EN
    , parameter int unsigned PERF_W = 32
`endif
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [1:0]  pc_mux_sel,
    input  logic [31:0] jalr_target,
    input  logic [31:0] branch_target,
    input  logic [31:0] jal_target,
    input  logic        stall,
    input  logic        flush_if_de,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_de_valid,
    output logic [31:0] if_de_instr,
    output logic [31:0] if_de_pc,
    output logic [31:0] if_de_pc4,
    output logic        fetch_wait
`ifdef OTTER_FETCH_PERF_EN
    , output logic [PERF_W-1:0] perf_redirects
    , output logic [PERF_W-1:0] perf_wait_cycles
    , output logic [PERF_W-1:0] perf_stall_cycles
`endif
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d, pc_plus4, redirect_pc;
    logic         redirect, resp_ok;
    logic         skid_full, skid_push, skid_pop;
    logic [31:0]  skid_instr, skid_pc;
    logic         if_de_valid_q;
    logic [31:0]  if_de_instr_q, if_de_pc_q, if_de_pc4_q;

    assign pc_plus4 = pc_q + 32'd4;
    assign redirect = (pc_sel_t'(pc_mux_sel) != PC_PLUS4);
    assign resp_ok  = (state_q == S_WAIT) && imem_rvalid;

    always_comb begin
        redirect_pc = pc_plus4;
        case (pc_sel_t'(pc_mux_sel))
            PC_JALR:   redirect_pc = jalr_target;
            PC_BRANCH: redirect_pc = branch_target;
            PC_JAL:    redirect_pc = jal_target;
            default:   redirect_pc = pc_plus4;
        endcase
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        imem_req  = 1'b0;
        imem_addr = pc_q;
        case (state_q)
            S_REQ: begin
                imem_req = !redirect && !stall;
                if (imem_req && imem_gnt) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (redirect) begin
                    state_d = imem_rvalid ? S_REQ : S_DROP;
                end else if (imem_rvalid) begin
                    // pc advances on every accepted word, even one parked in the skid
                    pc_d      = pc_plus4;
                    imem_req  = !stall && !skid_full;
                    imem_addr = pc_plus4;
                    state_d   = (imem_req && imem_gnt) ? S_WAIT : S_REQ;
                end
            end
            S_DROP: begin
                if (imem_rvalid) state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase
        if (redirect) pc_d = redirect_pc;
        if (RST) imem_req = 1'b0;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign skid_push = resp_ok && !redirect && stall;
    assign skid_pop  = skid_full && !stall && !redirect;

    otter_fetch_skid u_skid (
        .CLK     (CLK),
        .RST     (RST),
        .push_i  (skid_push),
        .pop_i   (skid_pop),
        .clear_i (redirect),
        .instr_i (imem_rdata),
        .pc_i    (pc_q),
        .full_o  (skid_full),
        .instr_o (skid_instr),
        .pc_o    (skid_pc)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            if_de_valid_q <= 1'b0;
            if_de_instr_q <= OTTER_NOP;
            if_de_pc_q    <= '0;
            if_de_pc4_q   <= '0;
        end else if (flush_if_de) begin
            if_de_valid_q <= 1'b0;
            if_de_instr_q <= OTTER_NOP;
        end else if (stall) begin
            if_de_valid_q <= if_de_valid_q;
        end else if (skid_pop) begin
            if_de_valid_q <= 1'b1;
            if_de_instr_q <= skid_instr;
            if_de_pc_q    <= skid_pc;
            if_de_pc4_q   <= skid_pc + 32'd4;
        end else if (resp_ok && !redirect) begin
            if_de_valid_q <= 1'b1;
            if_de_instr_q <= imem_rdata;
            if_de_pc_q    <= pc_q;
            if_de_pc4_q   <= pc_plus4;
        end else begin
            if_de_valid_q <= 1'b0;
            if_de_instr_q <= OTTER_NOP;
        end
    end

    assign if_de_valid = if_de_valid_q;
    assign if_de_instr = if_de_instr_q;
    assign if_de_pc    = if_de_pc_q;
    assign if_de_pc4   = if_de_pc4_q;
    assign fetch_wait  = ((state_q == S_WAIT) || (state_q == S_DROP)) && !skid_full;

`ifdef OTTER_FETCH_PERF_EN
    logic [PERF_W-1:0] perf_redir_q, perf_wait_q, perf_stall_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            perf_redir_q <= '0;
            perf_wait_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            if (redirect && (perf_redir_q != '1))  perf_redir_q <= perf_redir_q + 1'b1;
            if (fetch_wait && (perf_wait_q != '1)) perf_wait_q  <= perf_wait_q + 1'b1;
            if (stall && (perf_stall_q != '1))     perf_stall_q <= perf_stall_q + 1'b1;
        end
    end

    assign perf_redirects    = perf_redir_q;
    assign perf_wait_cycles  = perf_wait_q;
    assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_otter_fetch_stage.sv
// Directed, table-driven bench for otter_fetch_stage plus a reset-mid-transaction sequence.
module tb_otter_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        RST;
    logic [1:0]  pc_mux_sel;
    logic [31:0] jalr_target, branch_target, jal_target;
    logic        stall, flush_if_de;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt, imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_de_valid;
    logic [31:0] if_de_instr, if_de_pc, if_de_pc4;
    logic        fetch_wait;
`ifdef OTTER_FETCH_PERF_EN
    logic [31:0] perf_redirects, perf_wait_cycles, perf_stall_cycles;
`endif

    otter_fetch_stage dut (
        .CLK           (CLK),
        .RST           (RST),
        .pc_mux_sel    (pc_mux_sel),
        .jalr_target   (jalr_target),
        .branch_target (branch_target),
        .jal_target    (jal_target),
        .stall         (stall),
        .flush_if_de   (flush_if_de),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .if_de_valid   (if_de_valid),
        .if_de_instr   (if_de_instr),
        .if_de_pc      (if_de_pc),
        .if_de_pc4     (if_de_pc4),
        .fetch_wait    (fetch_wait)
`ifdef OTTER_FETCH_PERF_EN
        , .perf_redirects    (perf_redirects)
        , .perf_wait_cycles  (perf_wait_cycles)
        , .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] tgt;
        logic        stall, flush, gnt, rvalid;
        logic [31:0] rdata;
        logic        ex_req;
        logic [31:0] ex_addr;
        logic        ex_fw, ex_v;
        logic [31:0] ex_pc, ex_instr;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, wanted %h", name, act, exp);
    endtask

    function automatic void add(input logic [1:0] sel, input logic [31:0] tgt,
                                input logic st, input logic fl, input logic g, input logic rv,
                                input logic [31:0] rd, input logic ereq, input logic [31:0] eaddr,
                                input logic efw, input logic ev, input logic [31:0] epc,
                                input logic [31:0] einstr);
        vec_t v;
        v.sel = sel; v.tgt = tgt; v.stall = st; v.flush = fl; v.gnt = g; v.rvalid = rv;
        v.rdata = rd; v.ex_req = ereq; v.ex_addr = eaddr; v.ex_fw = efw; v.ex_v = ev;
        v.ex_pc = epc; v.ex_instr = einstr;
        vecs.push_back(v);
    endfunction

    // Unselected targets carry distinct junk so a wrong mux leg shows up.
    task automatic drive(input logic [1:0] sel, input logic [31:0] tgt, input logic st,
                         input logic fl, input logic g, input logic rv, input logic [31:0] rd);
        pc_mux_sel    = sel;
        jalr_target   = (sel == 2'd1) ? tgt : 32'h0BAD_0004;
        branch_target = (sel == 2'd2) ? tgt : 32'h0BAD_0008;
        jal_target    = (sel == 2'd3) ? tgt : 32'h0BAD_000C;
        stall         = st;
        flush_if_de   = fl;
        imem_gnt      = g;
        imem_rvalid   = rv;
        imem_rdata    = rd;
    endtask

    task automatic check_ifde(input string tag, input logic ev, input logic [31:0] epc,
                              input logic [31:0] einstr);
        check({tag, " if_de_valid"}, {31'd0, if_de_valid}, {31'd0, ev});
        check({tag, " if_de_instr"}, if_de_instr, ev ? einstr : NOP);
        if (ev) begin
            check({tag, " if_de_pc"}, if_de_pc, epc);
            check({tag, " if_de_pc4"}, if_de_pc4, epc + 32'd4);
        end
    endtask

    initial begin
        RST = 1'b1;
        drive(2'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        // basic stream, 1-cycle memory
        add(0, 0, 0, 0, 1, 0, 0,            1, 32'h000, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 1, 32'hA000_0000, 1, 32'h004, 1, 1, 32'h000, 32'hA000_0000);
        add(0, 0, 0, 0, 1, 1, 32'hA000_0004, 1, 32'h008, 1, 1, 32'h004, 32'hA000_0004);
        add(0, 0, 0, 0, 1, 1, 32'hA000_0008, 1, 32'h00C, 1, 1, 32'h008, 32'hA000_0008);
        add(0, 0, 0, 0, 0, 1, 32'hA000_000C, 1, 32'h010, 1, 1, 32'h00C, 32'hA000_000C);
        // jal redirect while waiting: stale word dropped in S_DROP
        add(0, 0, 0, 0, 1, 0, 0,            1, 32'h010, 0, 0, 0, 0);
        add(3, 32'h100, 0, 0, 0, 0, 0,      0, 0, 1, 0, 0, 0);
        add(0, 0, 0, 0, 1, 1, 32'hA000_0010, 0, 0, 1, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0,            1, 32'h100, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 1, 32'hA000_0100, 1, 32'h104, 1, 1, 32'h100, 32'hA000_0100);
        // stall for 3 cycles with a response landing in the skid
        add(0, 0, 1, 0, 1, 1, 32'hA000_0104, 0, 0, 1, 1, 32'h100, 32'hA000_0100);
        add(0, 0, 1, 0, 1, 0, 0,            0, 0, 0, 1, 32'h100, 32'hA000_0100);
        add(0, 0, 1, 0, 1, 0, 0,            0, 0, 0, 1, 32'h100, 32'hA000_0100);
        add(0, 0, 0, 0, 1, 0, 0,            1, 32'h108, 0, 1, 32'h104, 32'hA000_0104);
        add(0, 0, 0, 0, 0, 1, 32'hA000_0108, 1, 32'h10C, 1, 1, 32'h108, 32'hA000_0108);
        // flush beats stall
        add(0, 0, 1, 1, 1, 0, 0,            0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0,            1, 32'h10C, 0, 0, 0, 0);
        // slow grant, slow response
        add(0, 0, 0, 0, 0, 1, 32'hA000_010C, 1, 32'h110, 1, 1, 32'h10C, 32'hA000_010C);
        add(0, 0, 0, 0, 0, 0, 0,            1, 32'h110, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0,            1, 32'h110, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0,            1, 32'h110, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0,            1, 32'h110, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0,            0, 0, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0,            0, 0, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 32'hA000_0110, 1, 32'h114, 1, 1, 32'h110, 32'hA000_0110);
        // jalr to the top word withdraws the pending request, then wraps to 0
        add(1, 32'hFFFF_FFFC, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0,            1, 32'hFFFF_FFFC, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 1, 32'h1234_5678, 1, 32'h000, 1, 1, 32'hFFFF_FFFC, 32'h1234_5678);
        add(0, 0, 0, 0, 0, 1, 32'hA000_0000, 1, 32'h004, 1, 1, 32'h000, 32'hA000_0000);
        // branch in the same cycle as rvalid: straight to S_REQ
        add(0, 0, 0, 0, 1, 0, 0,            1, 32'h004, 0, 0, 0, 0);
        add(2, 32'h200, 0, 0, 1, 1, 32'hA000_0004, 0, 0, 1, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0,            1, 32'h200, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 32'hA000_0200, 1, 32'h204, 1, 1, 32'h200, 32'hA000_0200);
        // redirect during stall empties the skid
        add(0, 0, 0, 0, 1, 0, 0,            1, 32'h204, 0, 0, 0, 0);
        add(0, 0, 1, 0, 1, 1, 32'hA000_0204, 0, 0, 1, 0, 0, 0);
        add(3, 32'h300, 1, 0, 1, 0, 0,      0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0,            1, 32'h300, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 32'hA000_0300, 1, 32'h304, 1, 1, 32'h300, 32'hA000_0300);

        repeat (2) @(posedge CLK);
        #2;
        check("reset imem_req", {31'd0, imem_req}, 32'd0);
        check("reset fetch_wait", {31'd0, fetch_wait}, 32'd0);
        check_ifde("reset", 1'b0, 32'h0, NOP);
        check("reset if_de_pc", if_de_pc, 32'h0);
        check("reset if_de_pc4", if_de_pc4, 32'h0);
        @(posedge CLK);
        #1;
        RST = 1'b0;

        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("v%0d", i);
            drive(vecs[i].sel, vecs[i].tgt, vecs[i].stall, vecs[i].flush,
                  vecs[i].gnt, vecs[i].rvalid, vecs[i].rdata);
            #1;
            check({tag, " imem_req"}, {31'd0, imem_req}, {31'd0, vecs[i].ex_req});
            if (vecs[i].ex_req) check({tag, " imem_addr"}, imem_addr, vecs[i].ex_addr);
            check({tag, " fetch_wait"}, {31'd0, fetch_wait}, {31'd0, vecs[i].ex_fw});
            @(posedge CLK);
            #1;
            check_ifde(tag, vecs[i].ex_v, vecs[i].ex_pc, vecs[i].ex_instr);
        end

        // Reset in the middle of a transaction; the orphan rvalid afterwards is ignored.
        drive(2'd0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        #1;
        check("rst-seq req before", {31'd0, imem_req}, 32'd1);
        check("rst-seq addr before", imem_addr, 32'h304);
        @(posedge CLK);
        #1;
        imem_gnt = 1'b0;
        #2;
        RST = 1'b1;
        #1;
        check("rst-seq imem_req", {31'd0, imem_req}, 32'd0);
        check("rst-seq fetch_wait", {31'd0, fetch_wait}, 32'd0);
        check_ifde("rst-seq", 1'b0, 32'h0, NOP);
        check("rst-seq if_de_pc4", if_de_pc4, 32'h0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        drive(2'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0BAD_BAD0);
        #1;
        check("rst-seq req after", {31'd0, imem_req}, 32'd1);
        check("rst-seq addr after", imem_addr, 32'h0);
        @(posedge CLK);
        #1;
        check_ifde("rst-seq orphan", 1'b0, 32'h0, NOP);
        drive(2'd0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        @(posedge CLK);
        #1;
        drive(2'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA000_0000);
        @(posedge CLK);
        #1;
        check_ifde("rst-seq refetch", 1'b1, 32'h0, 32'hA000_0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
